// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state encoding and header field widths for the instruction loader
package loader_pkg;

    localparam int HDR_COUNT_W       = 16;
    localparam int HDR_PC_W          = 16;
    localparam int MAX_WORDS_DEFAULT = 2048;
    localparam int ADDR_W_DEFAULT    = 11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
`ifdef LOADER_CHECKSUM_EN
        ST_CSUM  = 3'd4,
`endif
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

endpackage

// File: rtl/instr_loader_if.sv
// rtl/instr_loader_if.sv - byte stream in and instruction-memory write bus out of the loader
interface loader_if #(
    parameter int ADDR_W = 11
);
    logic              rx_valid;
    logic              rx_ready;
    logic [7:0]        rx_data;
    logic              mem_wren;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data;

    // master is the loader: it consumes bytes and masters the memory write port
    modport master (
        input  rx_valid, rx_data,
        output rx_ready, mem_wren, mem_addr, mem_data
    );

    modport slave (
        output rx_valid, rx_data,
        input  rx_ready, mem_wren, mem_addr, mem_data
    );
endinterface

// File: rtl/instr_loader_byte_packer.sv
// rtl/instr_loader_byte_packer.sv - shifts four LSB-first bytes into a 32-bit word
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_done
);
    logic [1:0] byte_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word     <= '0;
            byte_cnt <= '0;
        end else if (clear) begin
            word     <= '0;
            byte_cnt <= '0;
        end else if (shift_en) begin
            word     <= {byte_in, word[31:8]};
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

    // high on the edge that shifts in the fourth byte; word is complete the cycle after
    assign word_done = shift_en && (byte_cnt == 2'd3);
endmodule

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - loads a length-prefixed image into instruction memory; LOADER_CHECKSUM_EN adds a trailing XOR check
module instr_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEFAULT,
    parameter int MAX_WORDS = MAX_WORDS_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    loader_if.master          bus,
    output logic [ADDR_W-1:0] start_pc,
    output logic              cpu_rst_n,
    output logic              done,
    output logic              err
);
    localparam logic [HDR_COUNT_W:0] MAX_WORDS_L = (HDR_COUNT_W+1)'(MAX_WORDS);

`ifdef LOADER_CHECKSUM_EN
    localparam state_t END_ST = ST_CSUM;
`else
    localparam state_t END_ST = ST_DONE;
`endif

    state_t                 state, state_nxt;
    logic                   go_hdr;
    logic                   ready;
    logic                   fire;
    logic [1:0]             hdr_idx;
    logic [7:0]             count_lo;
    logic [7:0]             pc_lo;
    logic [HDR_COUNT_W-1:0] count;
    logic [HDR_COUNT_W-1:0] words_done;
    logic [ADDR_W-1:0]      addr;
    logic [31:0]            pk_word;
    logic                   pk_done;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]             csum;
`endif

    assign fire = bus.rx_valid && ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        go_hdr    = 1'b0;
        unique case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_nxt = ST_HDR;
                    go_hdr    = 1'b1;
                end
            end
            ST_HDR: begin
                if (fire && hdr_idx == 2'd3) begin
                    if ({1'b0, count} > MAX_WORDS_L) state_nxt = ST_ERR;
                    else if (count != '0)            state_nxt = ST_DATA;
                    else                             state_nxt = END_ST;
                end
            end
            ST_DATA: begin
                if (pk_done) state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                if (words_done + 1'b1 == count) state_nxt = END_ST;
                else                            state_nxt = ST_DATA;
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (fire) state_nxt = (bus.rx_data == csum) ? ST_DONE : ST_ERR;
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ready = (state == ST_HDR) || (state == ST_DATA);
`ifdef LOADER_CHECKSUM_EN
        if (state == ST_CSUM) ready = 1'b1;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr_idx    <= '0;
            count_lo   <= '0;
            pc_lo      <= '0;
            count      <= '0;
            words_done <= '0;
            addr       <= '0;
            start_pc   <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else if (go_hdr) begin
            hdr_idx    <= '0;
            words_done <= '0;
            addr       <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
`ifdef LOADER_CHECKSUM_EN
            if (fire && (state == ST_HDR || state == ST_DATA))
                csum <= csum ^ bus.rx_data;
`endif
            if (fire && state == ST_HDR) begin
                hdr_idx <= hdr_idx + 2'd1;
                unique case (hdr_idx)
                    2'd0: count_lo <= bus.rx_data;
                    2'd1: count    <= {bus.rx_data, count_lo};
                    2'd2: pc_lo    <= bus.rx_data;
                    2'd3: start_pc <= ADDR_W'({bus.rx_data, pc_lo});
                    default: ;
                endcase
            end
            if (state == ST_WRITE) begin
                addr       <= addr + 1'b1;
                words_done <= words_done + 1'b1;
            end
        end
    end

    byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (go_hdr),
        .shift_en  (fire && state == ST_DATA),
        .byte_in   (bus.rx_data),
        .word      (pk_word),
        .word_done (pk_done)
    );

    assign bus.rx_ready = ready;
    assign bus.mem_wren = (state == ST_WRITE);
    assign bus.mem_addr = addr;
    assign bus.mem_data = pk_word;
    assign cpu_rst_n    = (state == ST_DONE);
    assign done         = (state == ST_DONE);
    assign err          = (state == ST_ERR);
endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameter ADDR_W, 11, instruction-memory word-address width.
REQ-002 SHALL have parameter MAX_WORDS, 2048, largest accepted image length in words.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a load.
REQ-006 SHALL have port rx_valid  input  1  upstream byte valid.
REQ-007 SHALL have port rx_data  input  8  upstream byte.
REQ-008 SHALL have port rx_ready  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port mem_wren  output  1  instruction-memory write enable.
REQ-010 SHALL have port mem_addr  output  ADDR_W  instruction-memory word address.
REQ-011 SHALL have port mem_data  output  32  instruction-memory write data.
REQ-012 SHALL have port start_pc  output  ADDR_W  CPU start address from the image header.
REQ-013 SHALL have port cpu_rst_n  output  1  active-low CPU reset; low holds the CPU.
REQ-014 SHALL have port done  output  1  image loaded, CPU released.
REQ-015 SHALL have port err  output  1  load aborted.

Function
REQ-016 SHALL implement the states IDLE, HDR, DATA, WRITE, CSUM, DONE and ERR.
REQ-017 SHALL transfer a byte only when rx_valid and rx_ready are both 1 in the same cycle.
REQ-018 SHALL drive rx_ready=1 only in HDR, DATA and CSUM.
REQ-019 SHALL take the image format as: count lo, count hi, pc lo, pc hi, then count words of 4 bytes each, least-significant byte first.
REQ-020 SHALL use bits [ADDR_W-1:0] of the 16-bit header pc as start_pc.
REQ-021 SHALL move IDLE->HDR on start, and also DONE->HDR and ERR->HDR on start; start in any other state SHALL be ignored.
REQ-022 SHALL, after the fourth header byte, go to ERR if count>MAX_WORDS, else to DATA if count>0, else to the end state (CSUM or DONE, per REQ-031).
REQ-023 SHALL enter WRITE after the fourth byte of each word and hold it for exactly one cycle with mem_wren=1, mem_addr=word index, mem_data=assembled word.
REQ-024 SHALL drive mem_wren=0 in every state other than WRITE.
REQ-025 SHALL start mem_addr at 0 for each load and increment it after each WRITE, wrapping modulo 2^ADDR_W.
REQ-026 SHALL leave WRITE for DATA if words remain, else for the end state.
REQ-027 SHALL drive cpu_rst_n=1 only in DONE; done=1 only in DONE; err=1 only in ERR.
REQ-028 SHALL ignore rx_valid while rx_ready=0; no byte is lost or double-counted.

Reset
REQ-029 SHALL, while rst=1 (asynchronous, including mid-load), force: state IDLE, rx_ready=0, mem_wren=0, mem_addr=0, mem_data=0, start_pc=0, cpu_rst_n=0, done=0, err=0, and clear the byte, word and checksum counters.
REQ-030 SHALL not write memory in the first cycle after rst deasserts.

Configuration
REQ-031 SHALL support macro LOADER_CHECKSUM_EN; when it is defined, the end state SHALL be CSUM, which accepts one byte and goes to DONE if the byte equals the XOR of all header and data bytes, else to ERR.
REQ-032 SHALL, when LOADER_CHECKSUM_EN is undefined, have no CSUM state or checksum logic; the end state SHALL be DONE.

Structure
REQ-033 SHALL place the state enum, the 16-bit header field widths and the MAX_WORDS default in shared package loader_pkg.
REQ-034 SHALL use a single sub-module, byte_packer, which shifts four bytes into a 32-bit word and flags when the word is complete.

Verification
REQ-035 SHALL test this: start, bytes 02 00 10 00, 78 56 34 12, EF BE AD DE -> writes 0x12345678@0 and 0xDEADBEEF@1, start_pc=0x010, done=1, cpu_rst_n=1.
REQ-036 SHALL test this: header count=0x0801 -> err=1, no mem_wren pulse, cpu_rst_n=0.
REQ-037 SHALL test this: count=0, pc=0x005 -> DONE (or CSUM 0x05 -> DONE) with zero writes.
REQ-038 SHALL test this: rx_valid held high across WRITE cycles -> rx_ready=0 there, each byte consumed once, data correct.
REQ-039 SHALL test this: rst pulsed after 6 data bytes, then a new load -> all outputs at reset values, second image written from address 0.
REQ-040 SHALL test this: with LOADER_CHECKSUM_EN, a one-word image and a correct checksum -> done=1; a wrong checksum -> err=1, and start then reloads successfully.
